// File: rtl/rename_unit.sv
// Register-rename stage: a 32-entry RAT plus a circular free list of physical tags, with a registered output toward the issue queue.
// Optional build macro RN_FL_BYPASS_EN lets a tag being freed go straight out as the new destination when the free list is empty.
module rename_unit #(
    parameter int NUM_PREGS = 64,
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id2rn_valid,
    output logic          rn2id_ready,
    input  logic [4:0]    id2rn_rd,
    input  logic [4:0]    id2rn_rs1,
    input  logic [4:0]    id2rn_rs2,
    input  logic          id2rn_reg_write,
    input  logic [31:0]   id2rn_pc,
    output logic          rn2iq_valid,
    input  logic          iq2rn_ready,
    output logic [PW-1:0] rn2iq_prd,
    output logic [PW-1:0] rn2iq_prs1,
    output logic [PW-1:0] rn2iq_prs2,
    output logic [PW-1:0] rn2iq_old_prd,
    output logic [31:0]   rn2iq_pc,
    input  logic          rob2rn_free_valid,
    input  logic [PW-1:0] rob2rn_free_preg,
    output logic [PW:0]   rn_free_count
);
    localparam int FL  = NUM_PREGS - 32;
    localparam int FLW = (FL > 1) ? $clog2(FL) : 1;

    logic [PW-1:0]  rat_q [32];
    logic [PW-1:0]  fl_q [FL];
    logic [FLW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]    count_q, count_d;

    logic           valid_q;
    logic [PW-1:0]  prd_q, prs1_q, prs2_q, old_prd_q;
    logic [31:0]    pc_q;

    logic           alloc, free_req, fl_empty, fl_full, slot_free, bypass;
    logic           accept, do_pop, do_bypass, do_push;
    logic [PW-1:0]  new_prd;
    logic [31:0]    rat_we;
    logic [FL-1:0]  fl_we;

    function automatic logic [FLW-1:0] wrap_inc(input logic [FLW-1:0] p);
        return (p == FLW'(FL - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        alloc     = id2rn_reg_write && (id2rn_rd != 5'd0);
        free_req  = rob2rn_free_valid && (rob2rn_free_preg != '0);
        fl_empty  = (count_q == '0);
        fl_full   = (count_q == (PW+1)'(FL));
        slot_free = !valid_q || iq2rn_ready;
    end

`ifdef RN_FL_BYPASS_EN
    assign bypass = fl_empty && alloc && free_req;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        rn2id_ready = slot_free && (!alloc || !fl_empty || bypass);
        accept      = id2rn_valid && rn2id_ready;
        do_pop      = accept && alloc && !bypass;
        do_bypass   = accept && bypass;
        // A bypassed tag never enters the list; a push into a full list is dropped.
        do_push     = free_req && !do_bypass && !fl_full;
        new_prd     = bypass ? rob2rn_free_preg : fl_q[head_q];
        head_d      = do_pop  ? wrap_inc(head_q) : head_q;
        tail_d      = do_push ? wrap_inc(tail_q) : tail_q;
        count_d     = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rat_we
            if (gi == 0) begin : g_zero
                assign rat_we[gi] = 1'b0;
            end else begin : g_map
                assign rat_we[gi] = accept && alloc && (id2rn_rd == 5'(gi));
            end
        end
        for (gi = 0; gi < FL; gi++) begin : g_fl_we
            assign fl_we[gi] = do_push && (tail_q == FLW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rat_q[i] <= PW'(i);
            for (int j = 0; j < FL; j++) fl_q[j] <= PW'(32 + j);
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= (PW+1)'(FL);
            valid_q   <= 1'b0;
            prd_q     <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            old_prd_q <= '0;
            pc_q      <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (rat_we[i]) rat_q[i] <= new_prd;
            end
            for (int j = 0; j < FL; j++) begin
                if (fl_we[j]) fl_q[j] <= rob2rn_free_preg;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Sources read the mapping before this cycle's RAT write.
            if (accept) begin
                valid_q   <= 1'b1;
                prs1_q    <= rat_q[id2rn_rs1];
                prs2_q    <= rat_q[id2rn_rs2];
                prd_q     <= alloc ? new_prd : '0;
                old_prd_q <= alloc ? rat_q[id2rn_rd] : '0;
                pc_q      <= id2rn_pc;
            end else if (iq2rn_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rn2iq_valid   = valid_q;
    assign rn2iq_prd     = prd_q;
    assign rn2iq_prs1    = prs1_q;
    assign rn2iq_prs2    = prs2_q;
    assign rn2iq_old_prd = old_prd_q;
    assign rn2iq_pc      = pc_q;
    assign rn_free_count = count_q;
endmodule

// File: doc/rename_unit.md
# rename_unit

Register-rename stage between the instruction decoder and the issue queue. Accepts one decoded instruction per cycle, maps architectural sources through a 32-entry register alias table (RAT) and allocates a fresh physical destination from a circular free list. Physical registers released at commit return to the free list. Output is a registered valid/ready stage toward the issue queue.

## Interface
- NUM_PREGS, 64, physical register count (power of two, > 32); PW = $clog2(NUM_PREGS); free-list depth FL = NUM_PREGS-32
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id2rn_valid  in  1  decoded instruction valid
- rn2id_ready  out  1  rename can accept this cycle
- id2rn_rd / id2rn_rs1 / id2rn_rs2  in  5 each  architectural registers
- id2rn_reg_write  in  1  instruction writes rd
- id2rn_pc  in  32  instruction PC
- rn2iq_valid  out  1  renamed instruction valid
- iq2rn_ready  in  1  issue queue accepts
- rn2iq_prd / rn2iq_prs1 / rn2iq_prs2 / rn2iq_old_prd  out  PW each  physical tags
- rn2iq_pc  out  32  PC passed through
- rob2rn_free_valid  in  1  commit releases a physical register
- rob2rn_free_preg  in  PW  released tag
- rn_free_count  out  PW+1  free-list occupancy

## Operation
- alloc = id2rn_reg_write && id2rn_rd != 0. x0 always maps to p0, never allocated, never remapped.
- rn2id_ready = (!rn2iq_valid || iq2rn_ready) && (!alloc || count != 0) [bypass case: see Configuration]. Combinational.
- accept = id2rn_valid && rn2id_ready. On accept, at the clock edge:
  - rn2iq_prs1 <= RAT[rs1], rn2iq_prs2 <= RAT[rs2] (pre-update values, so rs==rd reads the old mapping).
  - If alloc: rn2iq_prd <= FL[head]; rn2iq_old_prd <= RAT[rd]; RAT[rd] <= FL[head]; head wraps mod FL; count decrements.
  - If !alloc: rn2iq_prd <= 0, rn2iq_old_prd <= 0; RAT and free list unchanged.
  - rn2iq_pc <= id2rn_pc; rn2iq_valid <= 1.
- No accept and iq2rn_ready: rn2iq_valid <= 0. rn2iq_valid && !iq2rn_ready: all rn2iq_* held stable.
- Free: rob2rn_free_valid with preg != 0: FL[tail] <= preg, tail wraps mod FL, count increments. preg == 0 ignored. Push at count == FL is illegal; RTL drops it.
- Simultaneous alloc and free (count > 0): both happen, count unchanged.

## Timing
- Reset (async, immediate): RAT[i] = i; FL[j] = 32+j; head = tail = 0; count = FL; rn2iq_valid = 0; all rn2iq_* tags and pc = 0; rn_free_count = FL.
- Latency: 1 cycle from accept to rn2iq_valid.
- Throughput: 1 instruction/cycle with iq2rn_ready high and free list non-empty.
- Back-to-back dependency: instruction accepted in cycle N+1 sees RAT updates from cycle N.
- rst asserted mid-stream: in-flight output is discarded and all state returns to reset values; a pending free is lost.

## Configuration
- RN_FL_BYPASS_EN defined: when count == 0, alloc is pending and rob2rn_free_valid carries a non-zero preg in the same cycle, ready is asserted, and the freed tag is allocated directly as prd. Count stays 0; FL is not written.
- Not defined: the free is pushed and ready stays low that cycle. Allocation proceeds the following cycle, one-cycle stall.

## Test plan
- Reset -> rn_free_count=32 (NUM_PREGS=64), rn2iq_valid=0; accept rd=5,rs1=5,rs2=0,reg_write=1 -> next cycle prd=32, prs1=5, prs2=0, old_prd=5.
- Follow-up with rs1=5 in the next cycle -> prs1=32. Then rd=5 again -> prd=33, old_prd=32.
- rd=0 with reg_write=1 -> prd=0, old_prd=0, count unchanged. Store with reg_write=0 -> no allocation.
- Perform 32 allocations with no frees -> count=0. The next alloc instruction sees rn2id_ready=0. A non-alloc instruction is still accepted.
- Hold iq2rn_ready=0 for 3 cycles with valid output -> outputs stable, rn2id_ready=0, no RAT change. Release -> output consumed, next instruction accepted the same cycle.
- count=0 plus alloc plus free of p40 -> with RN_FL_BYPASS_EN: prd=40 the next cycle, count=0. Without: 1-cycle stall, then prd=40.
